// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// hazard_pkg : state and forward-select encodings for the hazard controller
// Rev 1.0
// ============================================================================
package hazard_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LOAD_STALL = 2'd1,
        MC_WAIT    = 2'd2
    } hz_state_e;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b10;
    localparam logic [1:0] FWD_MEM  = 2'b11;

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// hazard_ctrl_if : pipeline-side inputs and stall/flush/forward controls
// Rev 1.0
// ============================================================================
interface hazard_ctrl_if #(
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
);
    logic [ADDR_W-1:0] dec_rs1_addr;
    logic [ADDR_W-1:0] dec_rs2_addr;
    logic [ADDR_W-1:0] ex_rs1_addr;
    logic [ADDR_W-1:0] ex_rs2_addr;
    logic [ADDR_W-1:0] ex_rd_addr;
    logic              ex_reg_write_signal;
    logic              ex_mem_read;
    logic [ADDR_W-1:0] mem_reg_write_addr;
    logic              mem_reg_write_signal;
    logic [ADDR_W-1:0] wb_reg_write_addr;
    logic              wb_reg_write_signal;
    logic              pc_select;
    logic              mc_start;
    logic              mc_done;
    logic              stall_count_clr;

    logic [1:0]        forward_alu_a;
    logic [1:0]        forward_alu_b;
    logic              stall_fetch;
    logic              stall_decode;
    logic              stall_execute;
    logic              flush_fetch_decode_pipeline;
    logic              flush_dec_ex_pipeline;
    logic              flush_ex_mem_pipeline;
    logic [CNT_W-1:0]  stall_count;

    modport master (
        output dec_rs1_addr, dec_rs2_addr, ex_rs1_addr, ex_rs2_addr, ex_rd_addr,
               ex_reg_write_signal, ex_mem_read, mem_reg_write_addr,
               mem_reg_write_signal, wb_reg_write_addr, wb_reg_write_signal,
               pc_select, mc_start, mc_done, stall_count_clr,
        input  forward_alu_a, forward_alu_b, stall_fetch, stall_decode,
               stall_execute, flush_fetch_decode_pipeline, flush_dec_ex_pipeline,
               flush_ex_mem_pipeline, stall_count
    );

    modport slave (
        input  dec_rs1_addr, dec_rs2_addr, ex_rs1_addr, ex_rs2_addr, ex_rd_addr,
               ex_reg_write_signal, ex_mem_read, mem_reg_write_addr,
               mem_reg_write_signal, wb_reg_write_addr, wb_reg_write_signal,
               pc_select, mc_start, mc_done, stall_count_clr,
        output forward_alu_a, forward_alu_b, stall_fetch, stall_decode,
               stall_execute, flush_fetch_decode_pipeline, flush_dec_ex_pipeline,
               flush_ex_mem_pipeline, stall_count
    );
endinterface
`default_nettype wire

// File: rtl/hazard_fwd_sel.sv
`default_nettype none
// ============================================================================
// hazard_fwd_sel : per-operand EX forward selector, MEM result beats WB result
// Rev 1.0
// ============================================================================
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  wire logic [ADDR_W-1:0] src_addr_i,
    input  wire logic [ADDR_W-1:0] mem_addr_i,
    input  wire logic              mem_we_i,
    input  wire logic [ADDR_W-1:0] wb_addr_i,
    input  wire logic              wb_we_i,
    output logic      [1:0]        fwd_sel_o
);

    always_comb begin
        fwd_sel_o = FWD_NONE;
        if (mem_we_i && (mem_addr_i != '0) && (mem_addr_i == src_addr_i)) begin
            fwd_sel_o = FWD_MEM;
        end else if (wb_we_i && (wb_addr_i != '0) && (wb_addr_i == src_addr_i)) begin
            fwd_sel_o = FWD_WB;
        end
    end

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// hazard_ctrl : forwarding, load-use / multi-cycle stalls, branch flush and
//               saturating stall-cycle counter for the 5-stage core
// Rev 1.0
// ============================================================================
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int ADDR_W            = 5,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 32
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    hazard_ctrl_if.slave hz
);

    localparam logic [1:0] BUB_LOAD =
        2'((LOAD_STALL_CYCLES > 1) ? (LOAD_STALL_CYCLES - 2) : 0);

    hz_state_e        state_q, state_d;
    logic [1:0]       bub_q, bub_d;
    logic [CNT_W-1:0] stall_cnt_q;

    logic [1:0] fwd_a, fwd_b;
    logic       load_use;
    logic       st_f, st_d, st_e, fl_fd, fl_de, fl_em;

    hazard_fwd_sel #(.ADDR_W(ADDR_W)) u_fwd_a (
        .src_addr_i (hz.ex_rs1_addr),
        .mem_addr_i (hz.mem_reg_write_addr),
        .mem_we_i   (hz.mem_reg_write_signal),
        .wb_addr_i  (hz.wb_reg_write_addr),
        .wb_we_i    (hz.wb_reg_write_signal),
        .fwd_sel_o  (fwd_a)
    );

    hazard_fwd_sel #(.ADDR_W(ADDR_W)) u_fwd_b (
        .src_addr_i (hz.ex_rs2_addr),
        .mem_addr_i (hz.mem_reg_write_addr),
        .mem_we_i   (hz.mem_reg_write_signal),
        .wb_addr_i  (hz.wb_reg_write_addr),
        .wb_we_i    (hz.wb_reg_write_signal),
        .fwd_sel_o  (fwd_b)
    );

    assign load_use = hz.ex_mem_read && hz.ex_reg_write_signal && (hz.ex_rd_addr != '0) &&
                      ((hz.ex_rd_addr == hz.dec_rs1_addr) || (hz.ex_rd_addr == hz.dec_rs2_addr));

    // Controls depend on this cycle's inputs (a taken branch must flush in the same cycle)
    always_comb begin
        state_d = state_q;
        bub_d   = bub_q;
        st_f    = 1'b0;
        st_d    = 1'b0;
        st_e    = 1'b0;
        fl_fd   = 1'b0;
        fl_de   = 1'b0;
        fl_em   = 1'b0;
        case (state_q)
            IDLE: begin
                if (hz.pc_select) begin
                    fl_fd = 1'b1;
                    fl_de = 1'b1;
                end else if (hz.mc_start) begin
                    if (!hz.mc_done) begin
                        {st_f, st_d, st_e, fl_em} = 4'hF;
                        state_d = MC_WAIT;
                    end
                end else if (load_use) begin
                    {st_f, st_d, fl_de} = 3'b111;
                    if (LOAD_STALL_CYCLES > 1) begin
                        bub_d   = BUB_LOAD;
                        state_d = LOAD_STALL;
                    end
                end
            end
            LOAD_STALL: begin
                if (hz.pc_select) begin
                    fl_fd   = 1'b1;
                    fl_de   = 1'b1;
                    bub_d   = 2'd0;
                    state_d = IDLE;
                end else begin
                    {st_f, st_d, fl_de} = 3'b111;
                    if (bub_q == 2'd0) begin
                        state_d = IDLE;
                    end else begin
                        bub_d = bub_q - 2'd1;
                    end
                end
            end
            MC_WAIT: begin
                if (!hz.mc_done) begin
                    {st_f, st_d, st_e, fl_em} = 4'hF;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bub_q       <= 2'd0;
            stall_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            bub_q   <= bub_d;
            if (hz.stall_count_clr) begin
                stall_cnt_q <= '0;
            end else if (st_f && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

    // Gating with rst_n drops every control the instant reset asserts
    assign hz.forward_alu_a               = rst_n ? fwd_a : FWD_NONE;
    assign hz.forward_alu_b               = rst_n ? fwd_b : FWD_NONE;
    assign hz.stall_fetch                 = rst_n & st_f;
    assign hz.stall_decode                = rst_n & st_d;
    assign hz.stall_execute               = rst_n & st_e;
    assign hz.flush_fetch_decode_pipeline = rst_n & fl_fd;
    assign hz.flush_dec_ex_pipeline       = rst_n & fl_de;
    assign hz.flush_ex_mem_pipeline       = rst_n & fl_em;
    assign hz.stall_count                 = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// tb_hazard_ctrl : two configurations (2 load bubbles / 32-bit count and
//                  1 load bubble / 4-bit count) against a behavioural model
// Rev 1.0
// ============================================================================
module tb_hazard_ctrl;
    import hazard_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.ADDR_W(5), .CNT_W(32)) ifa ();
    hazard_ctrl_if #(.ADDR_W(5), .CNT_W(4))  ifb ();

    hazard_ctrl #(.ADDR_W(5), .LOAD_STALL_CYCLES(2), .CNT_W(32)) dut_a (.clk(clk), .rst_n(rst_n), .hz(ifa));
    hazard_ctrl #(.ADDR_W(5), .LOAD_STALL_CYCLES(1), .CNT_W(4))  dut_b (.clk(clk), .rst_n(rst_n), .hz(ifb));

    assign ifb.dec_rs1_addr         = ifa.dec_rs1_addr;
    assign ifb.dec_rs2_addr         = ifa.dec_rs2_addr;
    assign ifb.ex_rs1_addr          = ifa.ex_rs1_addr;
    assign ifb.ex_rs2_addr          = ifa.ex_rs2_addr;
    assign ifb.ex_rd_addr           = ifa.ex_rd_addr;
    assign ifb.ex_reg_write_signal  = ifa.ex_reg_write_signal;
    assign ifb.ex_mem_read          = ifa.ex_mem_read;
    assign ifb.mem_reg_write_addr   = ifa.mem_reg_write_addr;
    assign ifb.mem_reg_write_signal = ifa.mem_reg_write_signal;
    assign ifb.wb_reg_write_addr    = ifa.wb_reg_write_addr;
    assign ifb.wb_reg_write_signal  = ifa.wb_reg_write_signal;
    assign ifb.pc_select            = ifa.pc_select;
    assign ifb.mc_start             = ifa.mc_start;
    assign ifb.mc_done              = ifa.mc_done;
    assign ifb.stall_count_clr      = ifa.stall_count_clr;

    int checks = 0;
    int passes = 0;

    // Model: remaining load bubbles, multi-cycle wait flag, stall count
    int      rem  [2];
    bit      mcw  [2];
    longint  cnt  [2];
    int      nrem [2];
    bit      nmcw [2];
    longint  ncnt [2];
    int      NBUB [2] = '{2, 1};
    longint  CMAX [2] = '{64'hFFFF_FFFF, 64'd15};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [1:0] fwd(input logic [4:0] src, input logic [4:0] ma, input logic mwe,
                                       input logic [4:0] wa, input logic wwe);
        if (mwe && ma != 0 && ma == src) return 2'b11;
        if (wwe && wa != 0 && wa == src) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [9:0] act_vec(input int d);
        if (d == 0)
            return {ifa.forward_alu_a, ifa.forward_alu_b, ifa.stall_fetch, ifa.stall_decode,
                    ifa.stall_execute, ifa.flush_fetch_decode_pipeline, ifa.flush_dec_ex_pipeline,
                    ifa.flush_ex_mem_pipeline};
        return {ifb.forward_alu_a, ifb.forward_alu_b, ifb.stall_fetch, ifb.stall_decode,
                ifb.stall_execute, ifb.flush_fetch_decode_pipeline, ifb.flush_dec_ex_pipeline,
                ifb.flush_ex_mem_pipeline};
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            rem[d] = 0; mcw[d] = 0; cnt[d] = 0;
        end
    endtask

    task automatic set_idle();
        ifa.dec_rs1_addr = 0; ifa.dec_rs2_addr = 0; ifa.ex_rs1_addr = 0; ifa.ex_rs2_addr = 0;
        ifa.ex_rd_addr = 0; ifa.ex_reg_write_signal = 0; ifa.ex_mem_read = 0;
        ifa.mem_reg_write_addr = 0; ifa.mem_reg_write_signal = 0;
        ifa.wb_reg_write_addr = 0; ifa.wb_reg_write_signal = 0;
        ifa.pc_select = 0; ifa.mc_start = 0; ifa.mc_done = 0; ifa.stall_count_clr = 0;
    endtask

    // One clock: compare both DUTs against the model at negedge, advance model at posedge
    task automatic tick();
        logic [1:0] fa, fb;
        logic       lu, sf, sd, se, ffd, fde, fem;
        @(negedge clk);
        fa = fwd(ifa.ex_rs1_addr, ifa.mem_reg_write_addr, ifa.mem_reg_write_signal,
                 ifa.wb_reg_write_addr, ifa.wb_reg_write_signal);
        fb = fwd(ifa.ex_rs2_addr, ifa.mem_reg_write_addr, ifa.mem_reg_write_signal,
                 ifa.wb_reg_write_addr, ifa.wb_reg_write_signal);
        lu = ifa.ex_mem_read && ifa.ex_reg_write_signal && ifa.ex_rd_addr != 0 &&
             (ifa.ex_rd_addr == ifa.dec_rs1_addr || ifa.ex_rd_addr == ifa.dec_rs2_addr);
        for (int d = 0; d < 2; d++) begin
            {sf, sd, se, ffd, fde, fem} = 6'b0;
            nrem[d] = rem[d];
            nmcw[d] = mcw[d];
            if (mcw[d]) begin
                if (!ifa.mc_done) {sf, sd, se, fem} = 4'hF;
                else nmcw[d] = 0;
            end else if (rem[d] > 0) begin
                if (ifa.pc_select) begin ffd = 1; fde = 1; nrem[d] = 0; end
                else begin sf = 1; sd = 1; fde = 1; nrem[d] = rem[d] - 1; end
            end else if (ifa.pc_select) begin
                ffd = 1; fde = 1;
            end else if (ifa.mc_start) begin
                if (!ifa.mc_done) begin {sf, sd, se, fem} = 4'hF; nmcw[d] = 1; end
            end else if (lu) begin
                sf = 1; sd = 1; fde = 1; nrem[d] = NBUB[d] - 1;
            end
            check(d == 0 ? "ctrl_a" : "ctrl_b", 64'(act_vec(d)), 64'({fa, fb, sf, sd, se, ffd, fde, fem}));
            check(d == 0 ? "count_a" : "count_b",
                  d == 0 ? 64'(ifa.stall_count) : 64'(ifb.stall_count), cnt[d]);
            if (ifa.stall_count_clr) ncnt[d] = 0;
            else if (sf && cnt[d] < CMAX[d]) ncnt[d] = cnt[d] + 1;
            else ncnt[d] = cnt[d];
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            rem[d] = nrem[d]; mcw[d] = nmcw[d]; cnt[d] = ncnt[d];
        end
        #1;
    endtask

    task automatic set_load_use(input logic [4:0] rd);
        ifa.ex_mem_read = 1; ifa.ex_reg_write_signal = 1; ifa.ex_rd_addr = rd; ifa.dec_rs2_addr = rd;
    endtask

    int n_se;
    logic last_se;

    initial begin
        set_idle();
        model_reset();
        #3;
        check("reset_ctrl_a", 64'(act_vec(0)), 64'd0);
        check("reset_count_a", 64'(ifa.stall_count), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();

        // Forwarding: MEM wins over WB, r0 never forwards
        ifa.ex_rs1_addr = 5; ifa.ex_rs2_addr = 0;
        ifa.mem_reg_write_addr = 5; ifa.mem_reg_write_signal = 1;
        ifa.wb_reg_write_addr = 5; ifa.wb_reg_write_signal = 1;
        #1;
        check("fwd_a_mem", 64'(ifa.forward_alu_a), 64'(FWD_MEM));
        check("fwd_b_r0", 64'(ifa.forward_alu_b), 64'(FWD_NONE));
        tick();
        ifa.mem_reg_write_signal = 0; #1;
        check("fwd_a_wb", 64'(ifa.forward_alu_a), 64'(FWD_WB));
        tick();

        // Load-use with two bubbles
        set_idle(); ifa.stall_count_clr = 1; tick();
        set_idle(); set_load_use(3); tick();
        ifa.ex_mem_read = 0; #1;
        check("load_bubble2_a", 64'(ifa.stall_fetch), 64'd1);
        tick();
        #1;
        check("load_done_a", 64'(ifa.stall_fetch), 64'd0);
        check("load_count_a", 64'(ifa.stall_count), 64'd2);
        tick();

        // Multi-cycle op, done after 4 stall cycles
        set_idle(); n_se = 0;
        for (int i = 0; i < 5; i++) begin
            ifa.mc_start = (i == 0); ifa.mc_done = (i == 4); #1;
            n_se += int'(ifa.stall_execute); last_se = ifa.stall_execute;
            tick();
        end
        check("mc_stall_cycles", 64'(n_se), 64'd4);
        check("mc_done_cycle", 64'(last_se), 64'd0);

        // Branch outranks multi-cycle start and load-use
        set_idle(); set_load_use(7); ifa.mc_start = 1; ifa.pc_select = 1; #1;
        check("pc_prio", 64'({ifa.stall_fetch, ifa.stall_decode, ifa.stall_execute,
              ifa.flush_fetch_decode_pipeline, ifa.flush_dec_ex_pipeline, ifa.flush_ex_mem_pipeline}),
              64'b000110);
        tick();
        set_idle(); #1;
        check("pc_stays_idle", 64'(ifa.stall_fetch), 64'd0);
        tick();

        // Asynchronous reset during MC_WAIT
        ifa.mc_start = 1; ifa.ex_rs1_addr = 4; ifa.mem_reg_write_addr = 4; ifa.mem_reg_write_signal = 1;
        tick();
        ifa.mc_start = 0; tick();
        #2; rst_n = 1'b0; #1;
        check("rst_ctrl_a", 64'(act_vec(0)), 64'd0);
        check("rst_ctrl_b", 64'(act_vec(1)), 64'd0);
        check("rst_count_a", 64'(ifa.stall_count), 64'd0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        set_idle(); tick();

        // Saturation of the 4-bit counter
        ifa.stall_count_clr = 1; tick();
        set_idle(); set_load_use(9);
        for (int i = 0; i < 20; i++) tick();
        check("sat_count_b", 64'(ifb.stall_count), 64'd15);
        set_idle(); ifa.stall_count_clr = 1; tick();
        check("clr_count_b", 64'(ifb.stall_count), 64'd0);
        set_idle(); tick();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            ifa.dec_rs1_addr         = 5'($urandom_range(0, 3));
            ifa.dec_rs2_addr         = 5'($urandom_range(0, 3));
            ifa.ex_rs1_addr          = 5'($urandom_range(0, 3));
            ifa.ex_rs2_addr          = 5'($urandom_range(0, 3));
            ifa.ex_rd_addr           = 5'($urandom_range(0, 3));
            ifa.ex_reg_write_signal  = ($urandom_range(0, 3) != 0);
            ifa.ex_mem_read          = ($urandom_range(0, 2) == 0);
            ifa.mem_reg_write_addr   = 5'($urandom_range(0, 3));
            ifa.mem_reg_write_signal = $urandom_range(0, 1) != 0;
            ifa.wb_reg_write_addr    = 5'($urandom_range(0, 3));
            ifa.wb_reg_write_signal  = $urandom_range(0, 1) != 0;
            ifa.pc_select            = ($urandom_range(0, 7) == 0);
            ifa.mc_start             = ($urandom_range(0, 7) == 0);
            ifa.mc_done              = !ifa.mc_start && ($urandom_range(0, 3) == 0);
            ifa.stall_count_clr      = ($urandom_range(0, 31) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
